// File: rtl/icache_refill_controller.sv
// I-cache line refill sequencer: one line-aligned memory request per miss, LINE_WORDS beats written to the fill port.
// Beat-to-fillWE latency 1 cycle; memReqValid/memReqAddr held until memReqReady; response beats cannot be backpressured.
module icache_refill_controller #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          missValid,
  input  logic [ADDR_WIDTH-1:0]         missAddr,
  input  logic                          flush,
  output logic                          memReqValid,
  input  logic                          memReqReady,
  output logic [ADDR_WIDTH-1:0]         memReqAddr,
  input  logic                          memRespValid,
  input  logic [DATA_WIDTH-1:0]         memRespData,
  output logic                          fillWE,
  output logic [ADDR_WIDTH-1:0]         fillAddr,
  output logic [$clog2(LINE_WORDS)-1:0] fillWordIdx,
  output logic [DATA_WIDTH-1:0]         fillData,
  output logic                          fillDone,
  output logic                          busy
);

  localparam int IDX_W = $clog2(LINE_WORDS);
  localparam int OFF_W = $clog2(LINE_WORDS * DATA_WIDTH / 8);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, REQ, RECV, DONE} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] lineAddr;
  logic [IDX_W-1:0]      beatCnt;
  logic                  cancel;

  assign memReqAddr = lineAddr;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      lineAddr    <= '0;
      beatCnt     <= '0;
      cancel      <= 1'b0;
      memReqValid <= 1'b0;
      fillWE      <= 1'b0;
      fillAddr    <= '0;
      fillWordIdx <= '0;
      fillData    <= '0;
      fillDone    <= 1'b0;
    end else begin
      fillWE   <= 1'b0;
      fillDone <= 1'b0;
      case (state)
        IDLE: begin
          if (missValid && !flush) begin
            lineAddr    <= {missAddr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
            beatCnt     <= '0;
            cancel      <= 1'b0;
            memReqValid <= 1'b1;
            state       <= REQ;
          end
        end
        REQ: begin
          // A flush that races the handshake still has to drain the line it launched.
          if (memReqReady) begin
            memReqValid <= 1'b0;
            cancel      <= flush;
            state       <= RECV;
          end else if (flush) begin
            memReqValid <= 1'b0;
            state       <= IDLE;
          end
        end
        RECV: begin
          if (flush) cancel <= 1'b1;
          if (memRespValid) begin
            beatCnt     <= beatCnt + 1'b1;
            fillWE      <= !cancel && !flush;
            fillWordIdx <= beatCnt;
            fillData    <= memRespData;
            fillAddr    <= lineAddr;
            if (beatCnt == LAST_IDX) begin
              fillDone <= !cancel && !flush;
              state    <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_refill_controller.sv
// Directed bench for icache_refill_controller: transaction-level model compared every cycle plus literal checks per scenario.
module tb_icache_refill_controller;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 4;
  localparam int LB = LW * DW / 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          missValid = 1'b0;
  logic [AW-1:0] missAddr = '0;
  logic          flush = 1'b0;
  logic          memReqReady = 1'b0;
  logic          memRespValid = 1'b0;
  logic [DW-1:0] memRespData = '0;
  logic          memReqValid;
  logic [AW-1:0] memReqAddr;
  logic          fillWE;
  logic [AW-1:0] fillAddr;
  logic [1:0]    fillWordIdx;
  logic [DW-1:0] fillData;
  logic          fillDone;
  logic          busy;

  icache_refill_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_WORDS(LW)) dut (
    .clk(clk), .rst(rst), .missValid(missValid), .missAddr(missAddr), .flush(flush),
    .memReqValid(memReqValid), .memReqReady(memReqReady), .memReqAddr(memReqAddr),
    .memRespValid(memRespValid), .memRespData(memRespData),
    .fillWE(fillWE), .fillAddr(fillAddr), .fillWordIdx(fillWordIdx), .fillData(fillData),
    .fillDone(fillDone), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level model: a refill is "active" from miss acceptance until its last beat,
  // "granted" once the request is accepted, followed by one finishing cycle.
  bit            m_active, m_granted, m_cancel, m_fin;
  int            m_beats;
  logic [AW-1:0] m_line;
  bit            e_we, e_done;
  int            e_idx;
  logic [DW-1:0] e_data;
  logic [AW-1:0] e_waddr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 0; m_granted <= 0; m_cancel <= 0; m_fin <= 0; m_beats <= 0;
      m_line <= '0; e_we <= 0; e_done <= 0; e_idx <= 0; e_data <= '0; e_waddr <= '0;
    end else begin
      e_we   <= 0;
      e_done <= 0;
      if (m_fin) begin
        m_fin <= 0;
      end else if (!m_active) begin
        if (missValid && !flush) begin
          m_active <= 1; m_granted <= 0; m_cancel <= 0; m_beats <= 0;
          m_line   <= (missAddr / LB) * LB;
        end
      end else if (!m_granted) begin
        if (memReqReady) begin
          m_granted <= 1;
          m_cancel  <= flush;
        end else if (flush) begin
          m_active <= 0;
        end
      end else begin
        if (flush) m_cancel <= 1;
        if (memRespValid) begin
          e_we    <= !(m_cancel || flush);
          e_idx   <= m_beats;
          e_data  <= memRespData;
          e_waddr <= m_line;
          m_beats <= m_beats + 1;
          if (m_beats + 1 == LW) begin
            m_active <= 0;
            m_fin    <= 1;
            e_done   <= !(m_cancel || flush);
          end
        end
      end
    end
  end

  // Per-cycle compare against the model, plus an event log for the literal checks.
  int        hs_cnt, done_cnt, done_cyc, fall_cyc, rise_cyc;
  logic [AW-1:0] hs_addr;
  logic [1:0]    done_idx;
  logic          done_we, prev_busy, prev_req;
  logic [1:0]    wr_idx[$];
  logic [DW-1:0] wr_dat[$];

  always @(negedge clk) begin
    chk("busy", busy, m_active || m_fin);
    chk("req_vld", memReqValid, m_active && !m_granted);
    if (m_active && !m_granted) chk("req_addr", memReqAddr, m_line);
    chk("fill_we", fillWE, e_we);
    if (e_we) begin
      chk("fill_idx", fillWordIdx, e_idx);
      chk("fill_data", fillData, e_data);
      chk("fill_addr", fillAddr, e_waddr);
    end
    chk("fill_done", fillDone, e_done);
    if (memReqValid && memReqReady) begin
      hs_cnt  <= hs_cnt + 1;
      hs_addr <= memReqAddr;
    end
    if (fillWE) begin
      wr_idx.push_back(fillWordIdx);
      wr_dat.push_back(fillData);
    end
    if (fillDone) begin
      done_cnt <= done_cnt + 1;
      done_idx <= fillWordIdx;
      done_we  <= fillWE;
      done_cyc <= cyc;
    end
    if (prev_busy && !busy) fall_cyc <= cyc;
    if (!prev_req && memReqValid) rise_cyc <= cyc;
    prev_busy <= busy;
    prev_req  <= memReqValid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_log();
    hs_cnt = 0; done_cnt = 0; hs_addr = '0;
    wr_idx.delete();
    wr_dat.delete();
  endtask

  task automatic send_beats(input logic [DW-1:0] base, input int gap);
    for (int i = 0; i < LW; i++) begin
      memRespValid = 1'b1;
      memRespData  = base + DW'(i);
      tick();
      memRespValid = 1'b0;
      if (i < LW - 1)
        for (int g = 0; g < gap; g++) tick();
    end
  endtask

  task automatic check_writes(input string tag, input logic [DW-1:0] base, input int n);
    chk({tag, "_wr_count"}, wr_idx.size(), n);
    for (int i = 0; i < n && i < wr_idx.size(); i++) begin
      chk({tag, "_wr_idx"}, wr_idx[i], i);
      chk({tag, "_wr_data"}, wr_dat[i], base + DW'(i));
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #1 rst = 1'b1;
    #2;
    chk("rst_req_vld", memReqValid, 0);
    chk("rst_req_addr", memReqAddr, 0);
    chk("rst_fill_we", fillWE, 0);
    chk("rst_fill_done", fillDone, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fill_addr", fillAddr, 0);
    chk("rst_fill_data", fillData, 0);
    tick();
    rst = 1'b0;
    tick();

    // Basic refill
    clear_log();
    missAddr = 32'h1000_0034; missValid = 1'b1; memReqReady = 1'b1;
    tick();
    settle();
    chk("basic_req_addr", memReqAddr, 32'h1000_0030);
    tick();
    send_beats(32'hA0, 0);
    missValid = 1'b0; memReqReady = 1'b0;
    settle();
    chk("basic_done_on_last", done_we && done_idx == 2'd3, 1);
    tick(); tick();
    settle();
    chk("basic_hs_count", hs_cnt, 1);
    chk("basic_hs_addr", hs_addr, 32'h1000_0030);
    check_writes("basic", 32'hA0, 4);
    chk("basic_done_count", done_cnt, 1);
    chk("basic_busy_fall", fall_cyc - done_cyc, 1);

    // Request backpressure and gapped beats
    clear_log();
    missAddr = 32'h3000_0048; missValid = 1'b1; memReqReady = 1'b0;
    tick();
    for (int s = 0; s < 3; s++) begin
      settle();
      chk("stall_req_addr", memReqAddr, 32'h3000_0040);
      chk("stall_req_vld", memReqValid, 1);
      tick();
    end
    memReqReady = 1'b1;
    tick();
    memReqReady = 1'b0;
    send_beats(32'hB0, 1);
    missValid = 1'b0;
    settle();
    chk("gap_done_on_last", done_we && done_idx == 2'd3, 1);
    tick(); tick();
    settle();
    chk("gap_hs_count", hs_cnt, 1);
    check_writes("gap", 32'hB0, 4);
    chk("gap_done_count", done_cnt, 1);

    // Miss coincident with flush in IDLE is dropped
    missAddr = 32'h4000_0010; missValid = 1'b1; flush = 1'b1;
    tick();
    settle();
    chk("idle_flush_busy", busy, 0);
    flush = 1'b0;

    // Flush in REQ before ready
    clear_log();
    tick();
    tick();
    flush = 1'b1; missValid = 1'b0;
    tick();
    flush = 1'b0;
    tick(); tick(); tick();
    settle();
    chk("reqflush_hs_count", hs_cnt, 0);
    chk("reqflush_wr_count", wr_idx.size(), 0);
    chk("reqflush_done_count", done_cnt, 0);
    chk("reqflush_busy", busy, 0);

    // Flush in RECV after the first beat
    clear_log();
    missAddr = 32'h5000_0004; missValid = 1'b1; memReqReady = 1'b1;
    tick(); tick();
    memReqReady = 1'b0;
    memRespValid = 1'b1; memRespData = 32'hF00D_0000;
    tick();
    memRespValid = 1'b0; flush = 1'b1; missValid = 1'b0;
    tick();
    flush = 1'b0;
    for (int i = 1; i < LW; i++) begin
      memRespValid = 1'b1; memRespData = 32'hF00D_0000 + DW'(i);
      tick();
    end
    memRespValid = 1'b0;
    tick(); tick(); tick();
    settle();
    check_writes("recvflush", 32'hF00D_0000, 1);
    chk("recvflush_done_count", done_cnt, 0);
    chk("recvflush_busy", busy, 0);

    // Normal refill after the cancelled one
    clear_log();
    missAddr = 32'h2000_0000; missValid = 1'b1; memReqReady = 1'b1;
    tick(); tick();
    memReqReady = 1'b0;
    send_beats(32'hC0, 0);
    missValid = 1'b0;
    tick(); tick();
    settle();
    chk("after_flush_hs_addr", hs_addr, 32'h2000_0000);
    check_writes("after_flush", 32'hC0, 4);
    chk("after_flush_done_count", done_cnt, 1);

    // Async reset mid-RECV after two beats
    clear_log();
    missAddr = 32'h6000_0078; missValid = 1'b1; memReqReady = 1'b1;
    tick(); tick();
    memReqReady = 1'b0;
    memRespValid = 1'b1; memRespData = 32'hD0;
    tick();
    memRespData = 32'hD1;
    tick();
    memRespData = 32'hD2;
    #2 rst = 1'b1;
    #1;
    chk("arst_fill_we", fillWE, 0);
    chk("arst_busy", busy, 0);
    chk("arst_req_vld", memReqValid, 0);
    chk("arst_fill_done", fillDone, 0);
    chk("arst_fill_addr", fillAddr, 0);
    memRespValid = 1'b0; missValid = 1'b0;
    clear_log();
    tick();
    rst = 1'b0;
    tick(); tick(); tick();
    settle();
    chk("arst_wr_count", wr_idx.size(), 0);
    chk("arst_done_count", done_cnt, 0);
    missAddr = 32'h7000_00FC; missValid = 1'b1; memReqReady = 1'b1;
    tick();
    settle();
    chk("arst_new_req_addr", memReqAddr, 32'h7000_00F0);
    tick();
    memReqReady = 1'b0;
    send_beats(32'hE0, 0);
    missValid = 1'b0;
    tick(); tick();
    settle();
    check_writes("arst_refill", 32'hE0, 4);

    // Miss held across two refills with a new address presented while busy
    clear_log();
    missAddr = 32'h8000_0024; missValid = 1'b1; memReqReady = 1'b1;
    tick(); tick();
    missAddr = 32'h9000_0048;
    send_beats(32'h50, 0);
    settle();
    chk("held_first_hs_addr", hs_addr, 32'h8000_0020);
    chk("held_first_done", done_cnt, 1);
    tick(); tick();
    settle();
    chk("held_next_req_gap", rise_cyc - done_cyc, 2);
    chk("held_second_req_addr", memReqAddr, 32'h9000_0040);
    tick();
    memReqReady = 1'b0;
    send_beats(32'h60, 0);
    missValid = 1'b0;
    tick(); tick();
    settle();
    chk("held_hs_count", hs_cnt, 2);
    chk("held_done_count", done_cnt, 2);
    chk("held_wr_count", wr_idx.size(), 8);
    if (wr_idx.size() == 8) begin
      chk("held_second_first_data", wr_dat[4], 32'h60);
      chk("held_second_last_idx", wr_idx[7], 3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
